// File: rtl/game_sequencer.sv
// Round-level controller for the flappy-bird core: sequences idle, countdown, play, hit and
// game-over phases, and manages lives, banked score, high score and scroll speed.
module game_sequencer #(
   parameter int unsigned COUNT_TICKS  = 30,
   parameter int unsigned HIT_TICKS    = 20,
   parameter int unsigned LIVES_SINGLE = 3,
   parameter int unsigned LIVES_DUAL   = 1
) (
   input  logic        clk_100ms,
   input  logic        rst,
   input  logic        start_i,
   input  logic        mode_i,
   input  logic        fail_i,
   input  logic [15:0] score_i,
   output logic        core_rst_n_o,
   output logic        run_o,
   output logic [2:0]  phase_o,
   output logic [1:0]  countdown_o,
   output logic [2:0]  lives_o,
   output logic [15:0] total_score_o,
   output logic [15:0] high_score_o,
   output logic [1:0]  speed_o
);

   localparam int unsigned MaxTicks = (COUNT_TICKS > HIT_TICKS) ? COUNT_TICKS : HIT_TICKS;
   localparam int unsigned CntW     = $clog2(MaxTicks + 1);

   localparam logic [CntW-1:0] CntCount    = CntW'(COUNT_TICKS);
   localparam logic [CntW-1:0] CntHit      = CntW'(HIT_TICKS);
   localparam logic [CntW-1:0] CntOne      = CntW'(1);
   localparam logic [2:0]      LivesSingle = 3'(LIVES_SINGLE);
   localparam logic [2:0]      LivesDual   = 3'(LIVES_DUAL);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StCountdown = 3'd1,
      StPlay      = 3'd2,
      StHit       = 3'd3,
      StOver      = 3'd4
   } phase_e;

   phase_e          phase_q;
   logic            start_q;
   logic            armed_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      lives_q;
   logic [15:0]     bank_q;
   logic [15:0]     high_q;
   logic            core_rst_n_q;
   logic            run_q;

   logic            start_edge;
   logic [16:0]     sum_full;
   logic [15:0]     play_sum;
   logic [15:0]     total_score;
   logic [31:0]     cnt_ext;

   // armed_q blocks a start that was already held high when reset released
   assign start_edge = start_i & ~start_q & armed_q;

   assign sum_full = {1'b0, bank_q} + {1'b0, score_i};
   assign play_sum = sum_full[16] ? 16'hFFFF : sum_full[15:0];
   assign cnt_ext  = 32'(cnt_q);

   always_ff @(posedge clk_100ms or negedge rst) begin
      if (!rst) begin
         phase_q      <= StIdle;
         start_q      <= 1'b0;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         lives_q      <= '0;
         bank_q       <= '0;
         high_q       <= '0;
         core_rst_n_q <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         start_q <= start_i;
         if (!start_i) begin
            armed_q <= 1'b1;
         end
         unique case (phase_q)
            StIdle: begin
               bank_q       <= '0;
               core_rst_n_q <= 1'b0;
               run_q        <= 1'b0;
               if (start_edge) begin
                  lives_q <= mode_i ? LivesDual : LivesSingle;
                  cnt_q   <= CntCount;
                  phase_q <= StCountdown;
               end
            end
            StCountdown: begin
               run_q        <= 1'b0;
               core_rst_n_q <= 1'b1;
               if (cnt_q == CntOne) begin
                  cnt_q   <= '0;
                  run_q   <= 1'b1;
                  phase_q <= StPlay;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            StPlay: begin
               run_q        <= 1'b1;
               core_rst_n_q <= 1'b1;
               if (fail_i) begin
                  run_q   <= 1'b0;
                  lives_q <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                  bank_q  <= play_sum;
                  cnt_q   <= CntHit;
                  phase_q <= StHit;
               end
            end
            StHit: begin
               run_q        <= 1'b0;
               core_rst_n_q <= 1'b1;
               if (cnt_q == CntOne) begin
                  if (lives_q == 3'd0) begin
                     cnt_q   <= '0;
                     high_q  <= (bank_q > high_q) ? bank_q : high_q;
                     phase_q <= StOver;
                  end else begin
                     cnt_q        <= CntCount;
                     core_rst_n_q <= 1'b0;
                     phase_q      <= StCountdown;
                  end
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            StOver: begin
               run_q        <= 1'b0;
               core_rst_n_q <= 1'b1;
               if (start_edge) begin
                  core_rst_n_q <= 1'b0;
                  phase_q      <= StIdle;
               end
            end
            default: begin
               run_q        <= 1'b0;
               core_rst_n_q <= 1'b0;
               phase_q      <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      total_score = bank_q;
      if (phase_q == StPlay) begin
         total_score = play_sum;
      end else if (phase_q == StIdle) begin
         total_score = '0;
      end
   end

   always_comb begin
      countdown_o = 2'd0;
      if (phase_q == StCountdown) begin
         if (cnt_ext > 32'd20) begin
            countdown_o = 2'd3;
         end else if (cnt_ext > 32'd10) begin
            countdown_o = 2'd2;
         end else if (cnt_ext > 32'd0) begin
            countdown_o = 2'd1;
         end
      end
   end

   always_comb begin
      speed_o = 2'd0;
      if (phase_q == StPlay) begin
         if (total_score < 16'd10) begin
            speed_o = 2'd0;
         end else if (total_score < 16'd25) begin
            speed_o = 2'd1;
         end else if (total_score < 16'd50) begin
            speed_o = 2'd2;
         end else begin
            speed_o = 2'd3;
         end
      end
   end

   assign core_rst_n_o  = core_rst_n_q;
   assign run_o         = run_q;
   assign phase_o       = phase_q;
   assign lives_o       = lives_q;
   assign total_score_o = total_score;
   assign high_score_o  = high_q;

endmodule
